// File: rtl/vga_pkg.sv
// vga_pkg: cell encoding, colour map, default 640x480 timing and control-word type for scan-out
package vga_pkg;
    typedef enum logic [1:0] {EMPTY, SAND, STONE, WATER} cell_t;
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic vblank;
        logic frame_start;
    } ctl_t;
    localparam ctl_t CTL_RST = '{hsync: 1'b1, vsync: 1'b1, default: 1'b0};
    localparam logic [11:0] COL_EMPTY = 12'h000;
    localparam logic [11:0] COL_SAND  = 12'hDB5;
    localparam logic [11:0] COL_STONE = 12'h888;
    localparam logic [11:0] COL_WATER = 12'h33F;
    localparam int DEF_COLUMNS = 640;
    localparam int DEF_ROWS    = 480;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_CLK_DIV = 4;
    function automatic int h_total(input int cols, input int fp, input int sp, input int bp);
        return cols + fp + sp + bp;
    endfunction
    function automatic int v_total(input int rows, input int fp, input int sp, input int bp);
        return rows + fp + sp + bp;
    endfunction
    function automatic logic [11:0] cell_colour(input cell_t c);
        return c == SAND ? COL_SAND : c == STONE ? COL_STONE : c == WATER ? COL_WATER : COL_EMPTY;
    endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel divider, raster counters and raw sync/active/blanking/frame markers
module vga_timing
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = DEF_COLUMNS,
    parameter int ACTIVE_ROWS    = DEF_ROWS,
    parameter int H_FRONT        = DEF_H_FRONT,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BACK         = DEF_H_BACK,
    parameter int V_FRONT        = DEF_V_FRONT,
    parameter int V_SYNC         = DEF_V_SYNC,
    parameter int V_BACK         = DEF_V_BACK,
    parameter int CLK_DIV        = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic reset_ni,
    output logic tick_o,
    output logic active_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic vblank_o,
    output logic frame_start_o,
    output logic frame_end_o
);
    localparam int HT = h_total(ACTIVE_COLUMNS, H_FRONT, H_SYNC, H_BACK);
    localparam int VT = v_total(ACTIVE_ROWS, V_FRONT, V_SYNC, V_BACK);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic h_end, v_end;

    always_comb begin
        tick_o        = div_q == DW'(CLK_DIV - 1);
        h_end         = h_q == HW'(HT - 1);
        v_end         = v_q == VW'(VT - 1);
        div_d         = tick_o ? '0 : div_q + 1'b1;
        h_d           = !tick_o ? h_q : h_end ? '0 : h_q + 1'b1;
        v_d           = !(tick_o && h_end) ? v_q : v_end ? '0 : v_q + 1'b1;
        active_o      = h_q < HW'(ACTIVE_COLUMNS) && v_q < VW'(ACTIVE_ROWS);
        hsync_o       = !(h_q >= HW'(ACTIVE_COLUMNS + H_FRONT) && h_q < HW'(ACTIVE_COLUMNS + H_FRONT + H_SYNC));
        vsync_o       = !(v_q >= VW'(ACTIVE_ROWS + V_FRONT) && v_q < VW'(ACTIVE_ROWS + V_FRONT + V_SYNC));
        vblank_o      = v_q >= VW'(ACTIVE_ROWS);
        frame_start_o = tick_o && h_q == '0 && v_q == '0;
        frame_end_o   = tick_o && h_end && v_end;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end
endmodule

// File: rtl/vram_scanout.sv
// vram_scanout: VGA raster scan of cell VRAM with latency-matched sync/status and colour map
module vram_scanout
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = DEF_COLUMNS,
    parameter int ACTIVE_ROWS    = DEF_ROWS,
    parameter int H_FRONT        = DEF_H_FRONT,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BACK         = DEF_H_BACK,
    parameter int V_FRONT        = DEF_V_FRONT,
    parameter int V_SYNC         = DEF_V_SYNC,
    parameter int V_BACK         = DEF_V_BACK,
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int RD_LATENCY     = 1,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [DATA_WIDTH-1:0] vram_rd_data_i,
    output logic [ADDR_WIDTH-1:0] vram_rd_address_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic [11:0]           rgb_o,
    output logic                  video_on_o,
    output logic                  vblank_o,
    output logic                  frame_start_o
);
    localparam int D = RD_LATENCY + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ACTIVE_COLUMNS * ACTIVE_ROWS - 1);

    logic tick, act_raw, hs_raw, vs_raw, vb_raw, fs_raw, frame_end;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [11:0] rgb_q, rgb_d;
    ctl_t ctl_q [D];
    ctl_t ctl_d [D];

    vga_timing #(
        .ACTIVE_COLUMNS(ACTIVE_COLUMNS), .ACTIVE_ROWS(ACTIVE_ROWS),
        .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .CLK_DIV(CLK_DIV)
    ) u_timing (
        .clk_i(clk_i), .reset_ni(reset_ni), .tick_o(tick), .active_o(act_raw),
        .hsync_o(hs_raw), .vsync_o(vs_raw), .vblank_o(vb_raw),
        .frame_start_o(fs_raw), .frame_end_o(frame_end)
    );

    // control bits stage RD_LATENCY gates the colour register, which adds the final clock
    always_comb begin
        addr_d   = frame_end ? '0 : !(tick && act_raw) ? addr_q : addr_q == LAST ? '0 : addr_q + 1'b1;
        ctl_d[0] = '{hsync: hs_raw, vsync: vs_raw, active: act_raw, vblank: vb_raw, frame_start: fs_raw};
        for (int i = 1; i < D; i++) ctl_d[i] = ctl_q[i-1];
        rgb_d    = ctl_q[D-2].active ? cell_colour(cell_t'(vram_rd_data_i[1:0])) : COL_EMPTY;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            addr_q <= '0;
            rgb_q  <= '0;
            for (int i = 0; i < D; i++) ctl_q[i] <= CTL_RST;
        end else begin
            addr_q <= addr_d;
            rgb_q  <= rgb_d;
            ctl_q  <= ctl_d;
        end
    end

    assign vram_rd_address_o = addr_q;
    assign rgb_o             = rgb_q;
    assign hsync_o           = ctl_q[D-1].hsync;
    assign vsync_o           = ctl_q[D-1].vsync;
    assign video_on_o        = ctl_q[D-1].active;
    assign vblank_o          = ctl_q[D-1].vblank;
    assign frame_start_o     = ctl_q[D-1].frame_start;
endmodule
